branch_unit: RTL and testbench

Conditional-branch sequencer sitting between the control unit and the program counter. It latches a branch request, samples `flag_Z`/`flag_N` from the flags register one cycle later, and on a taken branch drives a one-cycle PC load with the latched target. It also keeps a saturating count of taken branches for debug.

---
 rtl/branch_unit.sv | 133 +++++++++++++
 tb/tb_branch_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// Conditional-branch sequencer: latches a branch request, evaluates the Z/N flags
// one cycle later, strobes a PC load on a taken branch and counts taken branches.
module branch_unit #(
    parameter int ADDR_WIDTH  = 11,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   branch_reset_n,
    input  logic                   branch_start,
    input  logic [2:0]             branch_op,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic                   flag_Z,
    input  logic                   flag_N,
    input  logic                   clear_count,
    output logic                   branch_busy,
    output logic                   pc_load,
    output logic [ADDR_WIDTH-1:0]  pc_target,
    output logic                   branch_done,
    output logic                   branch_taken,
    output logic                   branch_illegal,
    output logic [COUNT_WIDTH-1:0] taken_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_JMP = 3'b000;
    localparam logic [2:0] OP_BZ  = 3'b001;
    localparam logic [2:0] OP_BNZ = 3'b010;
    localparam logic [2:0] OP_BN  = 3'b011;
    localparam logic [2:0] OP_BP  = 3'b100;
    localparam logic [2:0] OP_BLE = 3'b101;
    localparam logic [2:0] OP_NOP = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    state_t                 state;
    state_t                 state_next;
    logic [2:0]             op_q;
    logic [ADDR_WIDTH-1:0]  target_q;
    logic [ADDR_WIDTH-1:0]  pc_target_q;
    logic                   taken_q;
    logic                   taken_next;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   accept;

    function automatic logic cond_taken(input logic [2:0] op, input logic z, input logic n);
        logic t;
        t = 1'b0;
        case (op)
            OP_JMP:  t = 1'b1;
            OP_BZ:   t = z;
            OP_BNZ:  t = ~z;
            OP_BN:   t = n;
            OP_BP:   t = ~n & ~z;
            OP_BLE:  t = z | n;
            OP_NOP:  t = 1'b0;
            OP_ILL:  t = 1'b0;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Saturating increment: the debug counter sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
        return (value == COUNT_MAX) ? value : value + COUNT_ONE;
    endfunction

    assign accept     = (state == IDLE) && branch_start;
    // Flags are looked at live during EVAL, not captured with the request.
    assign taken_next = cond_taken(op_q, flag_Z, flag_N);

    always_ff @(posedge clock or negedge branch_reset_n) begin
        if (!branch_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (branch_start) state_next = EVAL;
            EVAL:    state_next = taken_next ? LOAD : DONE;
            LOAD:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge branch_reset_n) begin
        if (!branch_reset_n) begin
            op_q        <= 3'b000;
            target_q    <= '0;
            pc_target_q <= '0;
            taken_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            if (accept) begin
                op_q     <= branch_op;
                target_q <= branch_target;
            end
            // pc_target only changes when a load is about to happen, so it holds otherwise.
            if (state == EVAL) begin
                taken_q <= taken_next;
                if (taken_next) begin
                    pc_target_q <= target_q;
                end
            end
            if (clear_count) begin
                count_q <= '0;
            end else if ((state == DONE) && taken_q) begin
                count_q <= sat_inc(count_q);
            end
        end
    end

    assign branch_busy    = (state != IDLE);
    assign pc_load        = (state == LOAD);
    assign pc_target      = pc_target_q;
    assign branch_done    = (state == DONE);
    assign branch_taken   = (state == DONE) && taken_q;
    assign branch_illegal = (state == DONE) && (op_q == OP_ILL);
    assign taken_count    = count_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios plus randomized branches
// compared against a table-driven reference of the condition codes and counter.
module tb_branch_unit;

    localparam int AW   = 11;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          branch_reset_n;
    logic          branch_start;
    logic [2:0]    branch_op;
    logic [AW-1:0] branch_target;
    logic          flag_Z;
    logic          flag_N;
    logic          clear_count;
    logic          branch_busy;
    logic          pc_load;
    logic [AW-1:0] pc_target;
    logic          branch_done;
    logic          branch_taken;
    logic          branch_illegal;
    logic [CW-1:0] taken_count;

    branch_unit #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clock          (clock),
        .branch_reset_n (branch_reset_n),
        .branch_start   (branch_start),
        .branch_op      (branch_op),
        .branch_target  (branch_target),
        .flag_Z         (flag_Z),
        .flag_N         (flag_N),
        .clear_count    (clear_count),
        .branch_busy    (branch_busy),
        .pc_load        (pc_load),
        .pc_target      (pc_target),
        .branch_done    (branch_done),
        .branch_taken   (branch_taken),
        .branch_illegal (branch_illegal),
        .taken_count    (taken_count)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Reference: bit {Z,N} of the mask says whether the op is taken for those flags.
    logic [3:0] taken_mask [0:7] = '{4'hF, 4'hC, 4'h3, 4'hA, 4'h1, 4'hE, 4'h0, 4'h0};
    int            mcount;
    logic [AW-1:0] last_tgt;

    function automatic logic ref_taken(input logic [2:0] op, input logic z, input logic n);
        logic [3:0] m;
        m = taken_mask[op];
        return m[{z, n}];
    endfunction

    function automatic int next_count(input int c, input logic t, input logic clr);
        if (clr) return 0;
        if (t) return (c >= CMAX) ? CMAX : c + 1;
        return c;
    endfunction

    // Observations gathered by do_branch
    int            obs_load_cyc, obs_loads, obs_done_cyc, obs_dones;
    logic [AW-1:0] obs_tgt, obs_done_tgt;
    logic          obs_taken, obs_ill, obs_busy1, obs_spur;
    logic [CW-1:0] obs_count;

    task automatic do_branch(input logic [2:0] op, input logic [AW-1:0] tgt,
                             input logic zs, input logic ns,
                             input logic ze, input logic ne, input logic clr);
        obs_load_cyc = 0; obs_loads = 0; obs_done_cyc = 0; obs_dones = 0;
        obs_tgt = '0; obs_done_tgt = '0; obs_taken = 1'b0; obs_ill = 1'b0;
        obs_busy1 = 1'b0; obs_spur = 1'b0;
        @(negedge clock);
        branch_start = 1'b1; branch_op = op; branch_target = tgt;
        flag_Z = zs; flag_N = ns;
        @(posedge clock);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            clear_count = 1'b0;
            if (c == 1) begin
                branch_start  = 1'b0;
                branch_op     = 3'($urandom);
                branch_target = AW'($urandom);
                flag_Z = ze; flag_N = ne;
                obs_busy1 = branch_busy;
            end
            if (pc_load) begin
                obs_loads++; obs_load_cyc = c; obs_tgt = pc_target;
            end
            if (branch_done) begin
                obs_dones++; obs_done_cyc = c; obs_taken = branch_taken;
                obs_ill = branch_illegal; obs_done_tgt = pc_target;
                if (clr) clear_count = 1'b1;
            end else if (branch_taken || branch_illegal) begin
                obs_spur = 1'b1;
            end
        end
        obs_count = taken_count;
    endtask

    task automatic test_reset();
        branch_reset_n = 1'b0; branch_start = 1'b0; branch_op = 3'b000;
        branch_target = '0; flag_Z = 1'b0; flag_N = 1'b0; clear_count = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({branch_busy, pc_load, pc_target, branch_done, branch_taken, branch_illegal, taken_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b load=%b tgt=%h done=%b taken=%b ill=%b cnt=%h want all 0",
                     branch_busy, pc_load, pc_target, branch_done, branch_taken, branch_illegal, taken_count);
        end
        branch_reset_n = 1'b1;
        mcount = 0; last_tgt = '0;
    endtask

    task automatic test_jmp();
        do_branch(3'b000, 11'h2A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mcount = next_count(mcount, 1'b1, 1'b0); last_tgt = 11'h2A5;
        vectors++;
        if (obs_busy1 !== 1'b1) begin miscompares++; $display("FAIL jmp_busy: got %b want 1", obs_busy1); end
        vectors++;
        if (obs_loads !== 1 || obs_load_cyc !== 2) begin
            miscompares++; $display("FAIL jmp_load: got %0d loads at cycle %0d want 1 at cycle 2", obs_loads, obs_load_cyc);
        end
        vectors++;
        if (obs_tgt !== 11'h2A5) begin miscompares++; $display("FAIL jmp_target: got %h want 2a5", obs_tgt); end
        vectors++;
        if (obs_done_cyc !== 3 || obs_taken !== 1'b1) begin
            miscompares++; $display("FAIL jmp_done: got cycle %0d taken %b want cycle 3 taken 1", obs_done_cyc, obs_taken);
        end
        vectors++;
        if (obs_count !== CW'(mcount)) begin miscompares++; $display("FAIL jmp_count: got %0d want %0d", obs_count, mcount); end
    endtask

    task automatic test_sweep();
        logic [1:0] zn;
        logic       t;
        for (int op = 1; op <= 6; op++) begin
            for (int k = 0; k < 4; k++) begin
                zn = 2'(k);
                t  = ref_taken(3'(op), zn[1], zn[0]);
                do_branch(3'(op), AW'($urandom), zn[1], zn[0], zn[1], zn[0], 1'b0);
                mcount = next_count(mcount, t, 1'b0);
                vectors++;
                if (obs_taken !== t || obs_dones !== 1) begin
                    miscompares++;
                    $display("FAIL sweep_taken op=%0d zn=%b: got taken %b dones %0d want taken %b dones 1", op, zn, obs_taken, obs_dones, t);
                end
                vectors++;
                if (obs_loads !== (t ? 1 : 0) || obs_done_cyc !== (t ? 3 : 2)) begin
                    miscompares++;
                    $display("FAIL sweep_timing op=%0d zn=%b: got loads %0d done cycle %0d want loads %0d done cycle %0d",
                             op, zn, obs_loads, obs_done_cyc, t ? 1 : 0, t ? 3 : 2);
                end
                if (t) last_tgt = obs_tgt;
            end
        end
        vectors++;
        if (obs_count !== CW'(mcount)) begin miscompares++; $display("FAIL sweep_count: got %0d want %0d", obs_count, mcount); end
    endtask

    task automatic test_flag_timing();
        do_branch(3'b001, 11'h111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        mcount = next_count(mcount, 1'b1, 1'b0); last_tgt = 11'h111;
        vectors++;
        if (obs_taken !== 1'b1 || obs_loads !== 1) begin
            miscompares++; $display("FAIL flag_late_set: got taken %b loads %0d want taken 1 loads 1", obs_taken, obs_loads);
        end
        do_branch(3'b001, 11'h222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (obs_taken !== 1'b0 || obs_loads !== 0 || obs_done_cyc !== 2) begin
            miscompares++; $display("FAIL flag_late_clear: got taken %b loads %0d done cycle %0d want 0 0 2", obs_taken, obs_loads, obs_done_cyc);
        end
    endtask

    task automatic test_start_held();
        int dones = 0, loads = 0, lows = 0;
        @(negedge clock);
        branch_start = 1'b1; branch_op = 3'b000; branch_target = 11'h155;
        flag_Z = 1'b0; flag_N = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 6) branch_start = 1'b0;
            if (branch_done) dones++;
            if (pc_load) loads++;
            if (c <= 7 && !branch_busy) lows++;
        end
        mcount = next_count(next_count(mcount, 1'b1, 1'b0), 1'b1, 1'b0); last_tgt = 11'h155;
        vectors++;
        if (dones !== 2 || loads !== 2) begin
            miscompares++; $display("FAIL held_accepts: got dones %0d loads %0d want 2 2", dones, loads);
        end
        vectors++;
        if (lows !== 1) begin miscompares++; $display("FAIL held_busy_gap: got %0d idle cycles want 1", lows); end
        vectors++;
        if (taken_count !== CW'(mcount)) begin miscompares++; $display("FAIL held_count: got %0d want %0d", taken_count, mcount); end
    endtask

    task automatic test_illegal();
        do_branch(3'b111, 11'h7FF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (obs_ill !== 1'b1 || obs_taken !== 1'b0 || obs_loads !== 0 || obs_done_cyc !== 2) begin
            miscompares++;
            $display("FAIL illegal_op: got ill %b taken %b loads %0d done cycle %0d want 1 0 0 2", obs_ill, obs_taken, obs_loads, obs_done_cyc);
        end
        vectors++;
        if (obs_spur !== 1'b0) begin miscompares++; $display("FAIL illegal_spurious: got %b want 0", obs_spur); end
    endtask

    task automatic test_counter_bounds();
        for (int i = 0; i < 20; i++) begin
            do_branch(3'b000, AW'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            mcount = next_count(mcount, 1'b1, 1'b0);
        end
        last_tgt = AW'(19);
        vectors++;
        if (obs_count !== 4'hF || mcount != CMAX) begin
            miscompares++; $display("FAIL count_saturate: got %h want f", obs_count);
        end
        do_branch(3'b000, 11'h0AA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        mcount = next_count(mcount, 1'b1, 1'b1); last_tgt = 11'h0AA;
        vectors++;
        if (obs_count !== 4'h0) begin miscompares++; $display("FAIL count_clear_priority: got %h want 0", obs_count); end
    endtask

    task automatic test_random();
        logic [2:0]    op;
        logic [AW-1:0] tgt;
        logic          zs, ns, ze, ne, clr, t;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom); tgt = AW'($urandom);
            zs = 1'($urandom); ns = 1'($urandom); ze = 1'($urandom); ne = 1'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            t = ref_taken(op, ze, ne);
            if (t) last_tgt = tgt;
            do_branch(op, tgt, zs, ns, ze, ne, clr);
            mcount = next_count(mcount, t, clr);
            vectors++;
            if (obs_taken !== t || obs_ill !== (op == 3'b111) || obs_dones !== 1 || obs_spur !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_decision %0d op=%0d: got taken %b ill %b dones %0d spur %b want taken %b ill %b",
                         i, op, obs_taken, obs_ill, obs_dones, obs_spur, t, op == 3'b111);
            end
            vectors++;
            if (obs_loads !== (t ? 1 : 0) || obs_done_cyc !== (t ? 3 : 2) || (t && obs_load_cyc !== 2)) begin
                miscompares++;
                $display("FAIL rand_timing %0d: got loads %0d at %0d done at %0d want taken=%b", i, obs_loads, obs_load_cyc, obs_done_cyc, t);
            end
            vectors++;
            if ((t && obs_tgt !== tgt) || obs_done_tgt !== last_tgt) begin
                miscompares++;
                $display("FAIL rand_target %0d: got load %h hold %h want %h", i, obs_tgt, obs_done_tgt, last_tgt);
            end
            vectors++;
            if (obs_count !== CW'(mcount)) begin miscompares++; $display("FAIL rand_count %0d: got %0d want %0d", i, obs_count, mcount); end
        end
    endtask

    task automatic test_mid_reset();
        int dones = 0;
        do_branch(3'b000, 11'h011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        branch_start = 1'b1; branch_op = 3'b000; branch_target = 11'h3C3;
        @(posedge clock);
        @(negedge clock);
        branch_start = 1'b0;
        @(negedge clock);
        vectors++;
        if (pc_load !== 1'b1) begin miscompares++; $display("FAIL midreset_in_load: got %b want 1", pc_load); end
        #1 branch_reset_n = 1'b0;
        #1;
        vectors++;
        if ({branch_busy, pc_load, pc_target, branch_done, branch_taken, branch_illegal, taken_count} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got busy=%b load=%b tgt=%h done=%b cnt=%h want all 0",
                     branch_busy, pc_load, pc_target, branch_done, taken_count);
        end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            if (c == 2) branch_reset_n = 1'b1;
            if (branch_done || pc_load) dones++;
        end
        mcount = 0; last_tgt = '0;
        vectors++;
        if (dones !== 0 || taken_count !== 4'h0) begin
            miscompares++; $display("FAIL midreset_aborted: got %0d strobes count %h want 0 0", dones, taken_count);
        end
        do_branch(3'b000, 11'h456, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mcount = next_count(mcount, 1'b1, 1'b0);
        vectors++;
        if (obs_done_cyc !== 3 || obs_tgt !== 11'h456 || obs_count !== CW'(mcount)) begin
            miscompares++;
            $display("FAIL midreset_recover: got done cycle %0d tgt %h count %0d want 3 456 %0d", obs_done_cyc, obs_tgt, obs_count, mcount);
        end
    endtask

    initial begin
        test_reset();
        test_jmp();
        test_sweep();
        test_flag_timing();
        test_start_held();
        test_illegal();
        test_counter_bounds();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
